// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles the two master request buses and the single-port data memory bus
// served by data_mem_arbiter.
//
//   Master side (per master n = 0/1):
//     mN_req_i    access request
//     mN_we_i     1 = write, 0 = read
//     mN_be_i     byte enables, bit k covers data[8k+7:8k]
//     mN_addr_i   13-bit byte address
//     mN_wdata_i  write data
//     mN_lock_i   ask to keep ownership on the next cycle
//     mN_gnt_o    combinational grant, access happens this cycle
//     mN_rvalid_o one-cycle read data valid pulse
//     mN_rdata_o  registered read data
//   Memory side:
//     mem_write_o, mem_be_sel_o, mem_addr_o, mem_data_o  to the memory
//     mem_data_i                                       combinational read data
//
// Modports: slave = arbiter view, master = environment (masters + memory).
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if;
   logic        m0_req_i;
   logic        m0_we_i;
   logic [3:0]  m0_be_i;
   logic [12:0] m0_addr_i;
   logic [31:0] m0_wdata_i;
   logic        m0_lock_i;
   logic        m0_gnt_o;
   logic        m0_rvalid_o;
   logic [31:0] m0_rdata_o;

   logic        m1_req_i;
   logic        m1_we_i;
   logic [3:0]  m1_be_i;
   logic [12:0] m1_addr_i;
   logic [31:0] m1_wdata_i;
   logic        m1_lock_i;
   logic        m1_gnt_o;
   logic        m1_rvalid_o;
   logic [31:0] m1_rdata_o;

   logic        mem_write_o;
   logic [3:0]  mem_be_sel_o;
   logic [12:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;

   modport slave (
      input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i, m0_lock_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, m1_lock_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output mem_write_o, mem_be_sel_o, mem_addr_o, mem_data_o,
      input  mem_data_i
   );

   modport master (
      output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i, m0_lock_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, m1_lock_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  mem_write_o, mem_be_sel_o, mem_addr_o, mem_data_o,
      output mem_data_i
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Two-master arbiter in front of a single-port data memory with combinational
// read and clocked write. One access per cycle is granted combinationally; a
// granted read returns its data one cycle later with an rvalid pulse.
// A master may lock ownership for up to MAX_HOLD consecutive grants; when
// both masters contend without a lock the grant alternates.
//
// Ports:
//   clk_i  single clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    data_mem_arbiter_if.slave (master buses + memory bus)
// Parameter:
//   MAX_HOLD  maximum consecutive locked grants to one master (2..255)
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   data_mem_arbiter_if.slave  bus
);

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 13;
   localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_t;

   owner_t              owner_q, owner_d;
   logic [7:0]          hold_q, hold_d;
   logic                gnt0, gnt1, any_gnt;
   logic                lock0_keep, lock1_keep;

   logic                sel_we;
   logic [3:0]          sel_be;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   logic [ADDR_W-1:0]   addr_p1;
   logic [DATA_W-1:0]   wdata_p1;
   logic                m0_vld_p1, m1_vld_p1;
   logic [DATA_W-1:0]   m0_rdata_p1, m1_rdata_p1;

   // Owner keeps the bus only while its locked run is still short of the limit.
   assign lock0_keep = (owner_q == OWN0) && bus.m0_req_i && bus.m0_lock_i && (hold_q < HOLD_LAST);
   assign lock1_keep = (owner_q == OWN1) && bus.m1_req_i && bus.m1_lock_i && (hold_q < HOLD_LAST);

   // ---- state register -------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q <= IDLE;
         hold_q  <= 8'd0;
      end else begin
         owner_q <= owner_d;
         hold_q  <= hold_d;
      end
   end

   // Grant selection and owner / hold-counter next state.
   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      owner_d = IDLE;
      hold_d  = 8'd0;
      if (!rst_i) begin
         if (lock0_keep) begin
            gnt0 = 1'b1;
         end else if (lock1_keep) begin
            gnt1 = 1'b1;
         end else if (bus.m0_req_i && bus.m1_req_i) begin
            // Contention: hand over to the master that did not own last.
            if (owner_q == OWN0) gnt1 = 1'b1;
            else                 gnt0 = 1'b1;
         end else if (bus.m0_req_i) begin
            gnt0 = 1'b1;
         end else if (bus.m1_req_i) begin
            gnt1 = 1'b1;
         end
      end

      // A locked re-grant that reached the limit (forced re-grant to a lone
      // requester) starts a fresh run, so the counter wraps to 0.
      if (gnt0) begin
         owner_d = OWN0;
         if ((owner_q == OWN0) && bus.m0_lock_i && (hold_q < HOLD_LAST))
            hold_d = hold_q + 8'd1;
      end else if (gnt1) begin
         owner_d = OWN1;
         if ((owner_q == OWN1) && bus.m1_lock_i && (hold_q < HOLD_LAST))
            hold_d = hold_q + 8'd1;
      end
   end

   assign any_gnt      = gnt0 | gnt1;
   assign bus.m0_gnt_o = gnt0;
   assign bus.m1_gnt_o = gnt1;

   // Granted master's request fields drive the memory bus.
   assign sel_we    = gnt1 ? bus.m1_we_i    : bus.m0_we_i;
   assign sel_be    = gnt1 ? bus.m1_be_i    : bus.m0_be_i;
   assign sel_addr  = gnt1 ? bus.m1_addr_i  : bus.m0_addr_i;
   assign sel_wdata = gnt1 ? bus.m1_wdata_i : bus.m0_wdata_i;

   assign bus.mem_write_o  = any_gnt & sel_we;
   assign bus.mem_be_sel_o = (any_gnt && sel_we) ? sel_be : 4'b0000;
   assign bus.mem_addr_o   = any_gnt ? sel_addr  : addr_p1;
   assign bus.mem_data_o   = any_gnt ? sel_wdata : wdata_p1;

   // ---- p0 -> p1: last driven memory address / data ----------------------
   always_ff @(posedge clk_i) begin
      if (any_gnt) begin
         addr_p1  <= sel_addr;
         wdata_p1 <= sel_wdata;
      end
   end

   // ---- p0 -> p1: read return -------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m0_vld_p1   <= 1'b0;
         m1_vld_p1   <= 1'b0;
         m0_rdata_p1 <= '0;
         m1_rdata_p1 <= '0;
      end else begin
         m0_vld_p1 <= gnt0 & ~bus.m0_we_i;
         m1_vld_p1 <= gnt1 & ~bus.m1_we_i;
         if (gnt0 && !bus.m0_we_i) m0_rdata_p1 <= bus.mem_data_i;
         if (gnt1 && !bus.m1_we_i) m1_rdata_p1 <= bus.mem_data_i;
      end
   end

   // Reset takes effect on the outputs immediately, so a read granted just
   // before reset never reports its data.
   assign bus.m0_rvalid_o = m0_vld_p1 & ~rst_i;
   assign bus.m1_rvalid_o = m1_vld_p1 & ~rst_i;
   assign bus.m0_rdata_o  = rst_i ? '0 : m0_rdata_p1;
   assign bus.m1_rdata_o  = rst_i ? '0 : m1_rdata_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Scoreboard bench for data_mem_arbiter (MAX_HOLD = 4). A reference model
// decides each cycle's grant from the arbitration rules, checks grant and
// memory-bus outputs, and queues the expected read returns; per-master
// monitors pop and compare whenever rvalid is presented.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
   localparam int MAXH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_arbiter_if bus();

   data_mem_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory attached to the DUT's memory port.
   logic [31:0] envmem [0:2047];
   assign bus.mem_data_i = envmem[bus.mem_addr_o[12:2]];
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 2048; i++) envmem[i] <= 32'h0;
      end else if (bus.mem_write_o) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be_sel_o[b]) envmem[bus.mem_addr_o[12:2]][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
      end
   end

   // Reference model state.
   typedef struct { int due; logic [31:0] data; } rd_t;
   rd_t         q0[$];
   rd_t         q1[$];
   logic [31:0] last_rd0 = 32'h0;
   logic [31:0] last_rd1 = 32'h0;
   logic [31:0] model_mem [0:2047];
   int          prev_m   = -1;   // master granted last cycle, -1 = none
   int          run_len  = 0;    // grants in the current locked run
   logic [12:0] held_addr;
   logic [31:0] held_data;
   bit          have_held = 0;
   int          ghist[$];       // DUT grant history: 0, 1 or -1

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---- monitors -------------------------------------------------------
   always @(negedge clk) begin : mon0
      rd_t e;
      if (bus.m0_rvalid_o) begin
         if (q0.size() == 0) check("m0_rvalid_unexpected", 32'd1, 32'd0);
         else begin
            e = q0.pop_front();
            check("m0_rvalid_latency", 32'(cyc), 32'(e.due));
            check("m0_rdata", bus.m0_rdata_o, e.data);
            last_rd0 = e.data;
         end
      end else begin
         if (q0.size() != 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            check("m0_rvalid_missing", 32'd0, 32'd1);
            last_rd0 = e.data;
         end else begin
            check("m0_rdata_hold", bus.m0_rdata_o, last_rd0);
         end
      end
   end

   always @(negedge clk) begin : mon1
      rd_t e;
      if (bus.m1_rvalid_o) begin
         if (q1.size() == 0) check("m1_rvalid_unexpected", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            check("m1_rvalid_latency", 32'(cyc), 32'(e.due));
            check("m1_rdata", bus.m1_rdata_o, e.data);
            last_rd1 = e.data;
         end
      end else begin
         if (q1.size() != 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            check("m1_rvalid_missing", 32'd0, 32'd1);
            last_rd1 = e.data;
         end else begin
            check("m1_rdata_hold", bus.m1_rdata_o, last_rd1);
         end
      end
   end

   // ---- stimulus helpers -------------------------------------------------
   task automatic drive_m0(bit req, bit we, logic [3:0] be, logic [12:0] addr, logic [31:0] wd, bit lock);
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_be_i = be;
      bus.m0_addr_i = addr; bus.m0_wdata_i = wd; bus.m0_lock_i = lock;
   endtask

   task automatic drive_m1(bit req, bit we, logic [3:0] be, logic [12:0] addr, logic [31:0] wd, bit lock);
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_be_i = be;
      bus.m1_addr_i = addr; bus.m1_wdata_i = wd; bus.m1_lock_i = lock;
   endtask

   task automatic set_rst(bit v);
      rst = v;
      if (v) begin
         q0.delete();
         q1.delete();
         last_rd0 = 32'h0;
         last_rd1 = 32'h0;
      end
   endtask

   // One cycle: evaluate the model against the DUT mid-cycle, then advance
   // to just after the next rising edge, ready for new inputs.
   task automatic step();
      int          g;
      bit          r0, r1, lk, we;
      logic [3:0]  be;
      logic [12:0] a;
      logic [31:0] wd;
      rd_t         e;
      @(negedge clk);
      g  = -1;
      r0 = bus.m0_req_i;
      r1 = bus.m1_req_i;
      if (!rst) begin
         if (prev_m == 0 && r0 && bus.m0_lock_i && run_len < MAXH)      g = 0;
         else if (prev_m == 1 && r1 && bus.m1_lock_i && run_len < MAXH) g = 1;
         else if (r0 && r1) g = (prev_m == 0) ? 1 : 0;
         else if (r0) g = 0;
         else if (r1) g = 1;
      end
      ghist.push_back(bus.m1_gnt_o ? 1 : (bus.m0_gnt_o ? 0 : -1));
      check("m0_gnt", 32'(bus.m0_gnt_o), 32'(g == 0));
      check("m1_gnt", 32'(bus.m1_gnt_o), 32'(g == 1));

      if (g >= 0) begin
         lk = (g == 1) ? bus.m1_lock_i  : bus.m0_lock_i;
         we = (g == 1) ? bus.m1_we_i    : bus.m0_we_i;
         be = (g == 1) ? bus.m1_be_i    : bus.m0_be_i;
         a  = (g == 1) ? bus.m1_addr_i  : bus.m0_addr_i;
         wd = (g == 1) ? bus.m1_wdata_i : bus.m0_wdata_i;
         check("mem_write", 32'(bus.mem_write_o), 32'(we));
         check("mem_be_sel", 32'(bus.mem_be_sel_o), we ? 32'(be) : 32'h0);
         check("mem_addr", 32'(bus.mem_addr_o), 32'(a));
         check("mem_data", bus.mem_data_o, wd);
         run_len   = (g == prev_m && lk && run_len < MAXH) ? run_len + 1 : 1;
         prev_m    = g;
         held_addr = a;
         held_data = wd;
         have_held = 1;
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) model_mem[a[12:2]][8*b +: 8] = wd[8*b +: 8];
         end else begin
            e.due  = cyc + 1;
            e.data = model_mem[a[12:2]];
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end else begin
         check("mem_write_idle", 32'(bus.mem_write_o), 32'h0);
         check("mem_be_sel_idle", 32'(bus.mem_be_sel_o), 32'h0);
         if (have_held) begin
            check("mem_addr_hold", 32'(bus.mem_addr_o), 32'(held_addr));
            check("mem_data_hold", bus.mem_data_o, held_data);
         end
         prev_m  = -1;
         run_len = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      drive_m0(0, 0, 4'h0, 13'h0, 32'h0, 0);
      drive_m1(0, 0, 4'h0, 13'h0, 32'h0, 0);
   endtask

   task automatic check_hist(string name, int first, int n, int exp_pat[$]);
      for (int i = 0; i < n; i++)
         check(name, 32'(ghist[first + i]), 32'(exp_pat[i]));
   endtask

   int exp_pat[$];
   int base;

   initial begin
      for (int i = 0; i < 2048; i++) model_mem[i] = 32'h0;
      rst = 1'b1;
      // Requests active during reset must not be granted.
      drive_m0(1, 1, 4'hF, 13'h0004, 32'h12345678, 1);
      drive_m1(1, 0, 4'hF, 13'h0008, 32'h0, 0);
      @(posedge clk);
      #1;
      set_rst(1);
      repeat (3) step();
      set_rst(0);
      idle_all();
      step();

      // Partial write then readback from the other master.
      drive_m0(1, 1, 4'b0101, 13'h0010, 32'hDEADBEEF, 0);
      step();
      idle_all();
      drive_m1(1, 0, 4'hF, 13'h0010, 32'h0, 0);
      step();
      idle_all();
      step();
      check("partial_write_readback", bus.m1_rdata_o, 32'h00AD00EF);

      // Write with no byte enables completes but changes nothing.
      drive_m0(1, 1, 4'b0000, 13'h0010, 32'hFFFFFFFF, 0);
      step();
      check("be0_granted", 32'(ghist[ghist.size()-1]), 32'd0);
      idle_all();
      drive_m0(1, 0, 4'hF, 13'h0010, 32'h0, 0);
      step();
      idle_all();
      step();
      check("be0_readback", bus.m0_rdata_o, 32'h00AD00EF);

      // Continuous contention, no lock: strict alternation starting at m0.
      base = ghist.size();
      for (int i = 0; i < 8; i++) begin
         drive_m0(1, 0, 4'hF, 13'(4*i), 32'h0, 0);
         drive_m1(1, 0, 4'hF, 13'(4*i + 32), 32'h0, 0);
         step();
      end
      idle_all();
      step();
      exp_pat = '{0, 1, 0, 1, 0, 1, 0, 1};
      check_hist("alternate", base, 8, exp_pat);

      // m0 locked against a contending m1: four m0 grants, one m1, then m0.
      base = ghist.size();
      drive_m0(1, 0, 4'hF, 13'h0010, 32'h0, 1);
      drive_m1(1, 0, 4'hF, 13'h0020, 32'h0, 0);
      repeat (7) step();
      idle_all();
      step();
      exp_pat = '{0, 0, 0, 0, 1, 0, 0};
      check_hist("hold_limit", base, 7, exp_pat);

      // m1 alone with lock: granted every cycle across the hold wrap.
      base = ghist.size();
      drive_m1(1, 0, 4'hF, 13'h0010, 32'h0, 1);
      repeat (20) step();
      idle_all();
      step();
      exp_pat.delete();
      for (int i = 0; i < 20; i++) exp_pat.push_back(1);
      check_hist("lone_lock", base, 20, exp_pat);

      // Reset right after an m1 read grant; then contention goes to m0.
      drive_m1(1, 0, 4'hF, 13'h0010, 32'h0, 0);
      step();
      drive_m0(1, 0, 4'hF, 13'h0014, 32'h0, 0);
      set_rst(1);
      step();
      set_rst(0);
      base = ghist.size();
      step();
      check("post_reset_first", 32'(ghist[base]), 32'd0);
      idle_all();
      step();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         drive_m0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 4'($urandom),
                  13'($urandom_range(0, 63)), $urandom, $urandom_range(0, 9) < 6);
         drive_m1($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 4'($urandom),
                  13'($urandom_range(0, 63)), $urandom, $urandom_range(0, 9) < 6);
         set_rst($urandom_range(0, 59) == 0);
         step();
      end
      set_rst(0);
      idle_all();
      repeat (3) step();
      check("drain", 32'(q0.size() + q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum number of consecutive locked grants to one master (legal range 2..255).
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports m0_req_i / m1_req_i, input, 1: access request.
REQ-005 SHALL have ports m0_we_i / m1_we_i, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have ports m0_be_i / m1_be_i, input, 4: byte enables; bit n covers data[8n+7:8n].
REQ-007 SHALL have ports m0_addr_i / m1_addr_i, input, 13: byte address; bits [1:0] passed through unchanged.
REQ-008 SHALL have ports m0_wdata_i / m1_wdata_i, input, 32: write data.
REQ-009 SHALL have ports m0_lock_i / m1_lock_i, input, 1: request to keep ownership on the next cycle.
REQ-010 SHALL have ports m0_gnt_o / m1_gnt_o, output, 1: combinational grant; the access is performed in this cycle.
REQ-011 SHALL have ports m0_rvalid_o / m1_rvalid_o, output, 1: one-cycle pulse, read data valid.
REQ-012 SHALL have ports m0_rdata_o / m1_rdata_o, output, 32: registered read data.
REQ-013 SHALL have ports mem_write_o (1), mem_be_sel_o (4), mem_addr_o (13), mem_data_o (32), all outputs, and mem_data_i (32), input: the port of the single-port data memory (combinational read, write on clock edge).

Function
REQ-014 SHALL hold an owner state: IDLE, OWN0, OWN1 (last master granted), plus an 8-bit hold counter.
REQ-015 Grant selection, in priority order, SHALL be:
- current owner has req, lock, and hold counter < MAX_HOLD-1 -> owner;
- only one master requests -> that master;
- both request -> the master not equal to the owner; from IDLE -> m0.
REQ-016 At most one gnt_o SHALL be high per cycle; gnt_o SHALL never be high without the matching req_i.
REQ-017 The granted master's we/be/addr/wdata SHALL drive the mem_* outputs in the same cycle.
REQ-018 mem_write_o SHALL be high only when a master is granted with we_i = 1; mem_be_sel_o SHALL equal that master's be_i then, and 4'b0000 otherwise.
REQ-019 With no grant, mem_write_o SHALL be 0 and mem_addr_o / mem_data_o SHALL hold their last driven values.
REQ-020 A granted read SHALL register mem_data_i into that master's rdata_o at the clock edge and pulse its rvalid_o in the following cycle (latency 1).
REQ-021 rdata_o SHALL hold its value until the next granted read for that master; a write SHALL NOT pulse rvalid_o.
REQ-022 A granted write with be_i = 4'b0000 SHALL complete the handshake and modify no byte.
REQ-023 On grant, the owner SHALL become the granted master.
REQ-024 The hold counter SHALL:
- increment (saturating at MAX_HOLD-1) when the same master is re-granted with lock_i high;
- reset to 0 on a grant to the other master, on a grant with lock_i low, or when no grant occurs.
REQ-025 With no request, owner SHALL go to IDLE.
REQ-026 When the hold limit forces release and the other master is not requesting, the owner SHALL be re-granted and the hold counter reset to 0.
REQ-027 Back-to-back reads SHALL be accepted every cycle; rvalid SHALL pulse on each following cycle.

Reset
REQ-028 While rst_i is high, owner SHALL be IDLE, hold counter 0, rvalid_o 0, rdata_o 32'h0, and gnt_o / mem_write_o 0 regardless of req_i.
REQ-029 Reset asserted in the cycle after a read grant SHALL suppress that rvalid pulse.
REQ-030 After reset release, the first simultaneous request SHALL go to m0.

Verification
REQ-031 Both masters request reads continuously with lock low -> grants alternate m0,m1,m0,...; each rvalid pulses one cycle after its grant with the memory word.
REQ-032 m0 writes 32'hDEADBEEF, be 4'b0101, addr 13'h0010 over prior 32'h0; m1 then reads 13'h0010 -> m1_rdata_o = 32'h00AD00EF with rvalid.
REQ-033 MAX_HOLD=4; m0 holds req+lock while m1 requests -> m0 granted 4 consecutive cycles, then m1 granted once, then m0 again.
REQ-034 m1 alone holds req+lock for 20 cycles with MAX_HOLD=4 -> m1 granted every cycle, hold counter wraps 0..3, no idle gaps.
REQ-035 Reset asserted during a granted m1 read -> no m1_rvalid_o pulse; next simultaneous request grants m0.
REQ-036 Write with be 4'b0000 -> gnt high, memory contents unchanged on readback.
